wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  Write-back stage plus architectural register file; consumes the MEM/WB pipeline register outputs.
//  - Selects the write-back value and writes it into a 32x32 GPR file.
//  - Serves the two ID-stage read ports, with same-cycle write-through bypass.
//  - Drives the forwarding bus (dst/data/enable) that the EX-stage forwarding mux consumes.
// PARAMETERS
//  DW      32  data width of GPRs, write-back data and read data
//  AW      5   register address width; the file holds 2**AW entries
//  PC_INC  4   constant added to pc for link write-back (memtoreg=2'b10)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  wb_valid     in   1   MEM/WB entry is valid this cycle; 0 = bubble
//  pc           in   DW  PC of the instruction in WB
//  aluresult    in   DW  ALU result from MEM/WB
//  memdata      in   DW  load data from MEM/WB
//  swdst        in   AW  destination register
//  regwrite     in   1   instruction writes a GPR
//  memtoreg     in   2   write-back source select
//  rs_addr      in   AW  read port A address
//  rt_addr      in   AW  read port B address
//  rs_data      out  DW  read port A data
//  rt_data      out  DW  read port B data
//  fwd_en       out  1   forwarding bus carries a valid GPR write
//  fwd_dst      out  AW  forwarding destination (same as swdst)
//  fwd_data     out  DW  forwarding value (same as write data)
//  retire_cnt   out  32  retired-instruction count; present only with WB_PERF_CNT_EN
// BEHAVIOUR
//  - wb_data (combinational) is selected by memtoreg:
//    - 00 -> aluresult
//    - 01 -> memdata
//    - 10 -> pc + PC_INC, modulo 2**DW
//    - 11 -> aluresult (reserved encoding)
//  - wr_en = rst_n & wb_valid & regwrite & (swdst != 0).
//  - On posedge clk with wr_en=1: gpr[swdst] <= wb_data. One write per cycle; latency 1 edge.
//  - gpr[0] is never written and always reads 0.
//  - Reads are combinational:
//    - rs_data = (rs_addr==0) ? 0 : (wr_en && rs_addr==swdst) ? wb_data : gpr[rs_addr]; rt_data likewise.
//    - The same-cycle bypass removes the WB->ID hazard; ID never sees stale data.
//    - rs_addr==rt_addr is legal; both ports return the identical value.
//  - Forwarding bus (combinational):
//    - fwd_en = wr_en.
//    - fwd_dst = swdst and fwd_data = wb_data regardless of fwd_en.
//  - Reset (rst_n=0, asynchronous):
//    - All gpr entries clear to 0 immediately.
//    - wr_en and fwd_en forced to 0; rs_data and rt_data read 0.
//    - A write pending on an edge where rst_n is low is discarded.
//    - Release is synchronous to the next clk edge; the first write can land on the first edge with rst_n=1.
//  - A bubble (wb_valid=0) or regwrite=0 leaves the file unchanged and deasserts fwd_en.
// CONFIGURATION
//  WB_PERF_CNT_EN defined:
//  - retire_cnt port exists.
//  - Increments by 1 on each posedge with rst_n=1 and wb_valid=1, whether or not the instruction writes a GPR.
//  - Resets to 0 asynchronously and wraps from 0xFFFFFFFF to 0.
//  WB_PERF_CNT_EN undefined:
//  - retire_cnt port and counter logic are absent.
//  - All other behaviour is identical.
// TESTING
//  1. Reset, then read all 32 addresses -> every rs_data/rt_data = 0.
//  2. valid=1, regwrite=1, swdst=5, memtoreg=00, aluresult=0x1234 -> next cycle rs_addr=5 gives 0x1234.
//  3. Same-cycle write swdst=7, memtoreg=01, memdata=0xCAFEF00D with rs_addr=rt_addr=7 -> both ports read 0xCAFEF00D combinationally; fwd_en=1, fwd_dst=7.
//  4. memtoreg=10, pc=0xFFFFFFFC, swdst=31 -> gpr[31]=0x00000000 (wrap); with pc=0x400 -> 0x404.
//  5. swdst=0 with regwrite=1, or wb_valid=0 with swdst=3 -> fwd_en=0; r0 reads 0; r3 unchanged.
//  6. Assert rst_n low mid-stream with writes pending -> file clears at once; with WB_PERF_CNT_EN, 10 valid cycles after release -> retire_cnt=10.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: MEM/WB entry in, ID read ports and EX forwarding bus out.
// The master drives the pipeline side; the slave is the write-back stage + GPR file.
interface wb_regfile_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wb_valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] aluresult;
    logic [DW-1:0] memdata;
    logic [AW-1:0] swdst;
    logic          regwrite;
    logic [1:0]    memtoreg;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          fwd_en;
    logic [AW-1:0] fwd_dst;
    logic [DW-1:0] fwd_data;

    modport master (
        output wb_valid, pc, aluresult, memdata, swdst, regwrite, memtoreg,
        output rs_addr, rt_addr,
        input  rs_data, rt_data, fwd_en, fwd_dst, fwd_data
    );

    modport slave (
        input  wb_valid, pc, aluresult, memdata, swdst, regwrite, memtoreg,
        input  rs_addr, rt_addr,
        output rs_data, rt_data, fwd_en, fwd_dst, fwd_data
    );
endinterface

// File: rtl/wb_regfile.sv
// Purpose: write-back select + 2**AW x DW GPR file with write-through read bypass and forwarding bus.
// Latency: writes land on the next clk edge; reads and forwarding are combinational.
// Backpressure: none, one write per cycle is always accepted. Optional retire counter: WB_PERF_CNT_EN.
module wb_regfile #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int PC_INC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_regfile_if.slave     bus
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]     retire_cnt
`endif
);
    localparam int NREG = 1 << AW;

    logic [DW-1:0] gpr_q [NREG];
    logic [DW-1:0] wb_data;
    logic          wr_en;

    always_comb begin
        wb_data = bus.aluresult;
        case (bus.memtoreg)
            2'b01:   wb_data = bus.memdata;
            2'b10:   wb_data = bus.pc + DW'(PC_INC);
            default: wb_data = bus.aluresult;
        endcase
    end

    // rst_n gates the enable so nothing is written or forwarded while reset is held.
    assign wr_en = rst_n & bus.wb_valid & bus.regwrite & (bus.swdst != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wr_en) begin
            gpr_q[bus.swdst] <= wb_data;
        end
    end

    // Write-through bypass: ID always sees the value being written this cycle.
    assign bus.rs_data = (bus.rs_addr == '0)                    ? '0      :
                         (wr_en && (bus.rs_addr == bus.swdst))  ? wb_data :
                                                                  gpr_q[bus.rs_addr];
    assign bus.rt_data = (bus.rt_addr == '0)                    ? '0      :
                         (wr_en && (bus.rt_addr == bus.swdst))  ? wb_data :
                                                                  gpr_q[bus.rt_addr];

    assign bus.fwd_en   = wr_en;
    assign bus.fwd_dst  = bus.swdst;
    assign bus.fwd_data = wb_data;

`ifdef WB_PERF_CNT_EN
    logic [31:0] retire_cnt_q;
    logic [31:0] retire_cnt_d;

    // Counts every valid WB entry, including ones that do not write a GPR.
    assign retire_cnt_d = bus.wb_valid ? retire_cnt_q + 32'd1 : retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif
endmodule
